// File: rtl/mux_41.sv
// Registered 4:1 multiplexer with capture qualifier and one-cycle output valid.
// Optional registered parity of out is compiled in with MUX_41_PARITY_EN.
module mux_41 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_sel,
`ifdef MUX_41_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] out_d, out_q;
  logic [1:0]       out_sel_d, out_sel_q;
  logic             out_valid_d, out_valid_q;

  // Data and select hold while idle; only out_valid drops back to zero.
  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_sel_d   = select;
      out_valid_d = 1'b1;
      case (select)
        2'b00:   out_d = in1;
        2'b01:   out_d = in2;
        2'b10:   out_d = in3;
        default: out_d = in4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_sel_q   <= 2'b00;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

`ifdef MUX_41_PARITY_EN
  logic out_parity_d, out_parity_q;

  // Parity of the next out value, so it lands on the same edge as out.
  always_comb out_parity_d = ^out_d;

  always_ff @(posedge clk) begin
    if (!rst_n) out_parity_q <= 1'b0;
    else        out_parity_q <= out_parity_d;
  end

  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_mux_41.sv
// Scoreboard bench for mux_41: stimulus pushes expected responses, monitor pops and compares.
module tb_mux_41;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic [1:0]   select = 2'b00;
  logic         in_valid = 1'b0;
  logic [W-1:0] out;
  logic [1:0]   out_sel;
  logic         out_valid;
`ifdef MUX_41_PARITY_EN
  logic         out_parity;
`endif

  mux_41 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .select(select), .in_valid(in_valid),
    .out(out), .out_sel(out_sel),
`ifdef MUX_41_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic [1:0]   sel;
    logic         vld;
    logic         par;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  bit           stim_done = 0;

  // Reference state: last captured word and the select that chose it.
  logic [W-1:0] m_out = '0;
  logic [1:0]   m_sel = 2'b00;

  task automatic drive(input logic r, input logic v, input logic [1:0] s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    logic [W-1:0] words [4];
    exp_t e;
    @(negedge clk);
    rst_n = r; in_valid = v; select = s;
    in1 = a; in2 = b; in3 = c; in4 = d;
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    if (!r) begin
      m_out = '0; m_sel = 2'b00; e.vld = 1'b0;
    end else if (v) begin
      m_out = words[s]; m_sel = s; e.vld = 1'b1;
    end else begin
      e.vld = 1'b0;
    end
    e.out = m_out;
    e.sel = m_sel;
    e.par = 1'b0;
    for (int i = 0; i < W; i++) e.par = e.par ^ m_out[i];
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a response, compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_valid", {31'd0, out_valid}, {31'd0, e.vld});
        chk("out", {{(32-W){1'b0}}, out}, {{(32-W){1'b0}}, e.out});
        chk("out_sel", {30'd0, out_sel}, {30'd0, e.sel});
`ifdef MUX_41_PARITY_EN
        chk("out_parity", {31'd0, out_parity}, {31'd0, e.par});
`endif
      end
    end
  end

  initial begin
    // Reset held two cycles with live, nonzero inputs.
    drive(0, 1, 2'b11, 4'h1, 4'h3, 4'h7, 4'hF);
    drive(0, 1, 2'b10, 4'h1, 4'h3, 4'h7, 4'hF);
    // Select stepped through all inputs back-to-back.
    for (int s = 0; s < 4; s++) drive(1, 1, s[1:0], 4'h1, 4'h3, 4'h7, 4'hF);
    // Capture 0111 then idle while select and data churn.
    drive(1, 1, 2'b10, 4'h1, 4'h3, 4'h7, 4'hF);
    for (int i = 0; i < 4; i++)
      drive(1, 0, i[1:0], 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    // Reset wins over a capture on the same edge, then capture resumes.
    drive(0, 1, 2'b11, 4'h1, 4'h3, 4'h7, 4'hF);
    drive(1, 1, 2'b11, 4'h1, 4'h3, 4'h7, 4'hF);
    // Parity pair: 0011 then 0111.
    drive(1, 1, 2'b01, 4'h1, 4'h3, 4'h7, 4'hF);
    drive(1, 1, 2'b10, 4'h1, 4'h3, 4'h7, 4'hF);
    // Mid-stream reset followed by idle: nothing may reappear.
    drive(1, 1, 2'b11, 4'h9, 4'hA, 4'hB, 4'hC);
    drive(0, 1, 2'b00, 4'h9, 4'hA, 4'hB, 4'hC);
    drive(1, 0, 2'b01, 4'h9, 4'hA, 4'hB, 4'hC);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
            2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    stim_done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    chk("stim_timeout", {31'd0, stim_done}, 32'd1);
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
